// File: rtl/vpe_master_param_if.sv
// Bus bundle for the variable processing element: clause writes, slave sums, control and results.
// The master modport is the element's own view; slave is the surrounding array's view.
interface vpe_master_param_if #(
  parameter int unsigned NCL  = 32,
  parameter int unsigned NSLV = 2,
  parameter int unsigned SW   = 8
);
  localparam int unsigned IW = $clog2(NCL);

  logic              WR_EN;
  logic [IW-1:0]     WR_IDX;
  logic              WR_C0;
  logic              WR_C1;
  logic              VI_LOAD;
  logic              VI_LOAD_VAL;
  logic              START;
  logic [NSLV-1:0]   MERGE_MASK;
  logic [NSLV-1:0]   SLV_VALID;
  logic [NSLV*SW-1:0] SLV_UP;
  logic [NSLV*SW-1:0] SLV_DOWN;
  logic              STOCHASTIC_MODE;
  logic              SEED_LOAD;
  logic [15:0]       SEED;
  logic              SATISFY_UP;
  logic              SATISFY_LEFT;
  logic              VI;
  logic              BUSY;
  logic              DONE;
  logic [SW-1:0]     SUM_UP_OUT;
  logic [SW-1:0]     SUM_DOWN_OUT;
  logic              SATISFY;

  modport master (
    input  WR_EN, WR_IDX, WR_C0, WR_C1, VI_LOAD, VI_LOAD_VAL, START, MERGE_MASK,
           SLV_VALID, SLV_UP, SLV_DOWN, STOCHASTIC_MODE, SEED_LOAD, SEED,
           SATISFY_UP, SATISFY_LEFT,
    output VI, BUSY, DONE, SUM_UP_OUT, SUM_DOWN_OUT, SATISFY
  );

  modport slave (
    output WR_EN, WR_IDX, WR_C0, WR_C1, VI_LOAD, VI_LOAD_VAL, START, MERGE_MASK,
           SLV_VALID, SLV_UP, SLV_DOWN, STOCHASTIC_MODE, SEED_LOAD, SEED,
           SATISFY_UP, SATISFY_LEFT,
    input  VI, BUSY, DONE, SUM_UP_OUT, SUM_DOWN_OUT, SATISFY
  );
endinterface

// File: rtl/vpe_master_param.sv
// Variable processing element: stores clause bits, merges up/down sums with slave partials
// and updates the variable value through an IDLE/GATHER/DECIDE pass.
module vpe_master_param #(
  parameter int unsigned NCL  = 32,
  parameter int unsigned NSLV = 2,
  parameter int unsigned SW   = 8
) (
  input logic                CLK,
  input logic                RESET_N,
  vpe_master_param_if.master io_bus
);
  localparam int unsigned   IW       = $clog2(NCL);
  localparam int unsigned   FW       = SW + 4;
  localparam logic [FW-1:0] SumMax   = {4'b0, {SW{1'b1}}};
  localparam logic [IW:0]   IdxLim   = (IW+1)'(NCL);
  localparam logic [15:0]   LfsrInit = 16'hACE1;

  typedef enum logic [1:0] {StIdle, StGather, StDecide} state_e;
  state_e r_state, w_state_nxt;

  logic [NCL-1:0] r_c0, r_c1;
  logic           r_vi, r_done, r_sat;
  logic [SW-1:0]  r_sum_up, r_sum_dn;
  logic [15:0]    r_lfsr, w_lfsr_adv, w_lfsr_nxt;
  logic [SW-1:0]  w_loc_up, w_loc_dn;
  logic [FW-1:0]  w_full_up, w_full_dn;
  logic [SW-1:0]  w_sat_up, w_sat_dn;
  logic           w_idle, w_gather_ok, w_load_sums, w_decide, w_clause_sat;

  // NCL < 2^SW is guaranteed by the SW constraint, so local counts fit in SW bits.
  always_comb begin
    w_loc_up = '0;
    w_loc_dn = '0;
    for (int i = 0; i < NCL; i++) begin
      w_loc_up = w_loc_up + {{(SW-1){1'b0}}, r_c0[i] & ~r_c1[i]};
      w_loc_dn = w_loc_dn + {{(SW-1){1'b0}}, r_c0[i] & r_c1[i]};
    end
  end

  always_comb begin
    w_full_up = {4'b0, w_loc_up};
    w_full_dn = {4'b0, w_loc_dn};
    for (int k = 0; k < NSLV; k++) begin
      if (io_bus.MERGE_MASK[k]) begin
        w_full_up = w_full_up + {4'b0, io_bus.SLV_UP[k*SW +: SW]};
        w_full_dn = w_full_dn + {4'b0, io_bus.SLV_DOWN[k*SW +: SW]};
      end
    end
    w_sat_up = (w_full_up > SumMax) ? {SW{1'b1}} : w_full_up[SW-1:0];
    w_sat_dn = (w_full_dn > SumMax) ? {SW{1'b1}} : w_full_dn[SW-1:0];
  end

  assign w_clause_sat = &(~r_c0 | (r_c1 ^ {NCL{r_vi}}));
  assign w_gather_ok  = &(io_bus.SLV_VALID | ~io_bus.MERGE_MASK);
  assign w_idle       = (r_state == StIdle);

  // Fibonacci LFSR, taps 16,14,13,11, shifting toward bit 0.
  assign w_lfsr_adv = {r_lfsr[0] ^ r_lfsr[2] ^ r_lfsr[3] ^ r_lfsr[5], r_lfsr[15:1]};
  always_comb begin
    w_lfsr_nxt = r_lfsr;
    if (io_bus.SEED_LOAD) begin
      w_lfsr_nxt = (io_bus.SEED == 16'h0000) ? LfsrInit : io_bus.SEED;
    end else if (w_decide) begin
      w_lfsr_nxt = w_lfsr_adv;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_load_sums = 1'b0;
    w_decide    = 1'b0;
    unique case (r_state)
      StIdle: begin
        if (io_bus.START && !io_bus.VI_LOAD) w_state_nxt = StGather;
      end
      StGather: begin
        if (w_gather_ok) begin
          w_load_sums = 1'b1;
          w_state_nxt = StDecide;
        end
      end
      StDecide: begin
        w_decide    = 1'b1;
        w_state_nxt = StIdle;
      end
      default: w_state_nxt = StIdle;
    endcase
  end

  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) r_state <= StIdle;
    else          r_state <= w_state_nxt;
  end

  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      r_c0     <= '0;
      r_c1     <= '0;
      r_vi     <= 1'b0;
      r_done   <= 1'b0;
      r_sat    <= 1'b0;
      r_sum_up <= '0;
      r_sum_dn <= '0;
      r_lfsr   <= LfsrInit;
    end else begin
      r_sat  <= w_clause_sat & io_bus.SATISFY_UP & io_bus.SATISFY_LEFT;
      r_done <= w_decide;
      r_lfsr <= w_lfsr_nxt;
      if (w_idle && io_bus.WR_EN && ({1'b0, io_bus.WR_IDX} < IdxLim)) begin
        r_c0[io_bus.WR_IDX] <= io_bus.WR_C0;
        r_c1[io_bus.WR_IDX] <= io_bus.WR_C1;
      end
      if (w_load_sums) begin
        r_sum_up <= w_sat_up;
        r_sum_dn <= w_sat_dn;
      end
      if (w_idle && io_bus.VI_LOAD) begin
        r_vi <= io_bus.VI_LOAD_VAL;
      end else if (w_decide) begin
        if (r_sum_up > r_sum_dn)          r_vi <= 1'b1;
        else if (r_sum_up < r_sum_dn)     r_vi <= 1'b0;
        else if (io_bus.STOCHASTIC_MODE)  r_vi <= w_lfsr_adv[0];
      end
    end
  end

  assign io_bus.VI           = r_vi;
  assign io_bus.BUSY         = !w_idle;
  assign io_bus.DONE         = r_done;
  assign io_bus.SUM_UP_OUT   = r_sum_up;
  assign io_bus.SUM_DOWN_OUT = r_sum_dn;
  assign io_bus.SATISFY      = r_sat;
endmodule

// File: tb/tb_vpe_master_param.sv
// Directed bench for vpe_master_param: per-cycle comparison against a pass-level model,
// plus hand-computed literal expectations for each scenario.
module tb_vpe_master_param;
  localparam int unsigned NCL  = 32;
  localparam int unsigned NSLV = 2;
  localparam int unsigned SW   = 8;
  localparam int unsigned IW   = $clog2(NCL);
  localparam int          SMAX = (1 << SW) - 1;

  logic CLK = 1'b0;
  logic RESET_N = 1'b0;
  int   n_checks = 0;
  int   n_fail = 0;
  bit   cmp_en = 1'b0;

  vpe_master_param_if #(.NCL(NCL), .NSLV(NSLV), .SW(SW)) bus ();

  vpe_master_param #(.NCL(NCL), .NSLV(NSLV), .SW(SW)) dut (
    .CLK    (CLK),
    .RESET_N(RESET_N),
    .io_bus (bus)
  );

  always #5 CLK = ~CLK;

  task automatic chk(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s actual=%0d required=%0d time=%0t", name, act, exp, $time);
    end
  endtask

  // Pass-level model: phase 0 idle, 1 waiting for slaves, 2 deciding.
  bit          m_c0[NCL];
  bit          m_c1[NCL];
  bit          m_vi, m_done, m_sat;
  int          m_phase, m_up, m_dn;
  logic [15:0] m_lfsr;

  function automatic int loc_count(input bit negated);
    int n = 0;
    for (int i = 0; i < NCL; i++) if (m_c0[i] && (m_c1[i] == negated)) n++;
    return n;
  endfunction

  function automatic int merged(input bit down);
    int s = loc_count(down);
    for (int k = 0; k < NSLV; k++) begin
      if (bus.MERGE_MASK[k]) s += down ? int'(bus.SLV_DOWN[k*SW +: SW])
                                       : int'(bus.SLV_UP[k*SW +: SW]);
    end
    return (s > SMAX) ? SMAX : s;
  endfunction

  function automatic bit all_clauses_sat();
    bit a = 1'b1;
    for (int i = 0; i < NCL; i++) if (m_c0[i] && (m_c1[i] == m_vi)) a = 1'b0;
    return a;
  endfunction

  function automatic bit slaves_ready();
    bit r = 1'b1;
    for (int k = 0; k < NSLV; k++) if (bus.MERGE_MASK[k] && !bus.SLV_VALID[k]) r = 1'b0;
    return r;
  endfunction

  always @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      for (int i = 0; i < NCL; i++) begin
        m_c0[i] <= 1'b0;
        m_c1[i] <= 1'b0;
      end
      m_vi <= 1'b0; m_done <= 1'b0; m_sat <= 1'b0;
      m_phase <= 0; m_up <= 0; m_dn <= 0;
      m_lfsr <= 16'hACE1;
    end else begin
      m_sat  <= all_clauses_sat() && bus.SATISFY_UP && bus.SATISFY_LEFT;
      m_done <= (m_phase == 2);
      if (bus.SEED_LOAD) m_lfsr <= (bus.SEED == 16'h0) ? 16'hACE1 : bus.SEED;
      else if (m_phase == 2)
        m_lfsr <= {m_lfsr[0] ^ m_lfsr[2] ^ m_lfsr[3] ^ m_lfsr[5], m_lfsr[15:1]};
      case (m_phase)
        0: begin
          if (bus.WR_EN && int'(bus.WR_IDX) < NCL) begin
            m_c0[bus.WR_IDX] <= bus.WR_C0;
            m_c1[bus.WR_IDX] <= bus.WR_C1;
          end
          if (bus.VI_LOAD) m_vi <= bus.VI_LOAD_VAL;
          else if (bus.START) m_phase <= 1;
        end
        1: if (slaves_ready()) begin
          m_up <= merged(1'b0);
          m_dn <= merged(1'b1);
          m_phase <= 2;
        end
        default: begin
          if (m_up > m_dn) m_vi <= 1'b1;
          else if (m_up < m_dn) m_vi <= 1'b0;
          else if (bus.STOCHASTIC_MODE) m_vi <= m_lfsr[1];  // bit 0 after one shift
          m_phase <= 0;
        end
      endcase
    end
  end

  always @(negedge CLK) begin
    if (cmp_en) begin
      chk("model_vi", bus.VI, m_vi);
      chk("model_busy", bus.BUSY, m_phase != 0);
      chk("model_done", bus.DONE, m_done);
      chk("model_satisfy", bus.SATISFY, m_sat);
      chk("model_sum_up", bus.SUM_UP_OUT, m_up);
      chk("model_sum_down", bus.SUM_DOWN_OUT, m_dn);
    end
  end

  task automatic wr(input int idx, input bit c0, input bit c1);
    bus.WR_EN = 1'b1; bus.WR_IDX = IW'(idx); bus.WR_C0 = c0; bus.WR_C1 = c1;
    @(negedge CLK);
    bus.WR_EN = 1'b0;
  endtask

  task automatic vi_load(input bit v);
    bus.VI_LOAD = 1'b1; bus.VI_LOAD_VAL = v;
    @(negedge CLK);
    bus.VI_LOAD = 1'b0;
  endtask

  task automatic pulse_start();
    bus.START = 1'b1;
    @(negedge CLK);
    bus.START = 1'b0;
  endtask

  task automatic wait_done(input string name, input int budget);
    int i = 0;
    while (bus.DONE !== 1'b1 && i < budget) begin
      @(negedge CLK);
      i++;
    end
    chk(name, int'(bus.DONE === 1'b1), 1);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog expired time=%0t", $time);
    $fatal(1);
  end

  initial begin
    bus.WR_EN = 0; bus.WR_IDX = '0; bus.WR_C0 = 0; bus.WR_C1 = 0;
    bus.VI_LOAD = 0; bus.VI_LOAD_VAL = 0; bus.START = 0;
    bus.MERGE_MASK = '0; bus.SLV_VALID = '0; bus.SLV_UP = '0; bus.SLV_DOWN = '0;
    bus.STOCHASTIC_MODE = 0; bus.SEED_LOAD = 0; bus.SEED = '0;
    bus.SATISFY_UP = 0; bus.SATISFY_LEFT = 0;
    repeat (2) @(negedge CLK);
    cmp_en = 1'b1;
    chk("reset_vi", bus.VI, 0);
    chk("reset_busy", bus.BUSY, 0);
    chk("reset_sum_up", bus.SUM_UP_OUT, 0);
    RESET_N = 1'b1;
    @(negedge CLK);

    // Local sums 5 up / 2 down, no slaves; check exact latency.
    for (int i = 0; i < 5; i++) wr(i, 1'b1, 1'b0);
    wr(5, 1'b1, 1'b1);
    wr(6, 1'b1, 1'b1);
    pulse_start();
    chk("lat_busy_n", bus.BUSY, 1);
    chk("lat_done_n", bus.DONE, 0);
    @(negedge CLK);
    chk("lat_sum_up", bus.SUM_UP_OUT, 5);
    chk("lat_sum_down", bus.SUM_DOWN_OUT, 2);
    chk("lat_done_n1", bus.DONE, 0);
    @(negedge CLK);
    chk("lat_done_n2", bus.DONE, 1);
    chk("lat_vi", bus.VI, 1);
    chk("lat_busy_n2", bus.BUSY, 0);
    @(negedge CLK);
    chk("lat_done_pulse", bus.DONE, 0);

    // Slave 0 late by 4 cycles; write and START while busy must be ignored.
    bus.MERGE_MASK = 2'b01; bus.SLV_VALID = 2'b00;
    bus.SLV_UP = {8'd0, 8'd3}; bus.SLV_DOWN = {8'd0, 8'd10};
    pulse_start();
    for (int i = 0; i < 4; i++) begin
      chk("gather_busy", bus.BUSY, 1);
      bus.WR_EN = (i == 0); bus.WR_IDX = IW'(10); bus.WR_C0 = 1'b1; bus.WR_C1 = 1'b0;
      bus.START = (i == 1);
      @(negedge CLK);
    end
    bus.WR_EN = 0; bus.START = 0;
    bus.SLV_VALID = 2'b01;
    wait_done("gather_done", 10);
    chk("gather_sum_up", bus.SUM_UP_OUT, 8);
    chk("gather_sum_down", bus.SUM_DOWN_OUT, 12);
    chk("gather_vi", bus.VI, 0);
    repeat (2) @(negedge CLK);
    chk("busy_start_dropped", bus.BUSY, 0);

    // Saturation: 5 + 255 + 255 clips to 255.
    bus.MERGE_MASK = 2'b11; bus.SLV_VALID = 2'b11;
    bus.SLV_UP = {8'd255, 8'd255}; bus.SLV_DOWN = '0;
    pulse_start();
    wait_done("sat_done", 10);
    chk("sat_sum_up", bus.SUM_UP_OUT, 255);
    chk("sat_sum_down", bus.SUM_DOWN_OUT, 2);
    chk("sat_vi", bus.VI, 1);

    // Tie 4/4: zero seed maps to ACE1, one shift gives 0x5670 -> bit0 = 0.
    wr(4, 1'b0, 1'b0);
    wr(10, 1'b0, 1'b0);
    bus.MERGE_MASK = 2'b01; bus.SLV_VALID = 2'b01;
    bus.SLV_UP = '0; bus.SLV_DOWN = {8'd0, 8'd2};
    bus.SEED_LOAD = 1'b1; bus.SEED = 16'h0000; bus.STOCHASTIC_MODE = 1'b1;
    vi_load(1'b1);
    bus.SEED_LOAD = 1'b0;
    pulse_start();
    wait_done("tie_rand_done", 10);
    chk("tie_sum_up", bus.SUM_UP_OUT, 4);
    chk("tie_sum_down", bus.SUM_DOWN_OUT, 4);
    chk("tie_rand_vi", bus.VI, 0);
    bus.STOCHASTIC_MODE = 1'b0;
    vi_load(1'b1);
    pulse_start();
    wait_done("tie_hold_done", 10);
    chk("tie_hold_vi", bus.VI, 1);
    // Seed 0x0002 shifts to 0x0001 -> bit0 = 1.
    bus.SEED_LOAD = 1'b1; bus.SEED = 16'h0002; bus.STOCHASTIC_MODE = 1'b1;
    vi_load(1'b0);
    bus.SEED_LOAD = 1'b0;
    pulse_start();
    wait_done("tie_seed2_done", 10);
    chk("tie_seed2_vi", bus.VI, 1);
    bus.STOCHASTIC_MODE = 1'b0;

    // VI_LOAD wins over a same-cycle START.
    bus.VI_LOAD = 1'b1; bus.VI_LOAD_VAL = 1'b0; bus.START = 1'b1;
    @(negedge CLK);
    bus.VI_LOAD = 1'b0; bus.START = 1'b0;
    chk("viload_wins_busy", bus.BUSY, 0);
    chk("viload_wins_vi", bus.VI, 0);

    // Satisfy: only clause 0 (C0=1,C1=1) left, so it holds iff VI = 0.
    for (int i = 1; i < 11; i++) wr(i, 1'b0, 1'b0);
    wr(0, 1'b1, 1'b1);
    bus.SATISFY_UP = 1'b1; bus.SATISFY_LEFT = 1'b1;
    vi_load(1'b1);
    @(negedge CLK);
    chk("sat_vi1", bus.SATISFY, 0);
    vi_load(1'b0);
    chk("sat_vi1_lag", bus.SATISFY, 0);
    @(negedge CLK);
    chk("sat_vi0", bus.SATISFY, 1);
    bus.SATISFY_LEFT = 1'b0;
    @(negedge CLK);
    chk("sat_left_low", bus.SATISFY, 0);
    bus.SATISFY_LEFT = 1'b1;

    // Reset in the middle of GATHER aborts the pass.
    vi_load(1'b1);
    bus.MERGE_MASK = 2'b01; bus.SLV_VALID = 2'b00;
    pulse_start();
    @(negedge CLK);
    chk("abort_busy_pre", bus.BUSY, 1);
    @(posedge CLK);
    #2 RESET_N = 1'b0;
    #1;
    chk("abort_busy", bus.BUSY, 0);
    chk("abort_vi", bus.VI, 0);
    chk("abort_done", bus.DONE, 0);
    chk("abort_sum_down", bus.SUM_DOWN_OUT, 0);
    repeat (2) @(negedge CLK);
    RESET_N = 1'b1;
    @(negedge CLK);
    bus.SLV_VALID = 2'b01; bus.SLV_UP = {8'd0, 8'd7}; bus.SLV_DOWN = {8'd0, 8'd1};
    pulse_start();
    wait_done("post_reset_done", 10);
    chk("post_reset_sum_up", bus.SUM_UP_OUT, 7);
    chk("post_reset_sum_down", bus.SUM_DOWN_OUT, 1);
    chk("post_reset_vi", bus.VI, 1);

    repeat (3) @(negedge CLK);
    cmp_en = 1'b0;
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end
endmodule
